// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SEND  = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first valid requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [ID_WIDTH-1:0] ptr_i,
    input  logic [NUM_REQ-1:0]  req_i,
    output logic [ID_WIDTH-1:0] gnt_id_o,
    output logic                gnt_valid_o
);

    logic [NUM_REQ-1:0] req_rot;
    logic [ID_WIDTH:0]  sum;

    // Walk offsets from the far end so the smallest offset wins.
    always_comb begin
        req_rot     = NUM_REQ'({req_i, req_i} >> ptr_i);
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        sum         = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req_rot[off]) begin
                sum = {1'b0, ptr_i} + (ID_WIDTH+1)'(off);
                if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                    sum = sum - (ID_WIDTH+1)'(NUM_REQ);
                end
                gnt_id_o    = sum[ID_WIDTH-1:0];
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler framing requester words as SYNC/HEADER/DATA/CHECKSUM
// packets and pacing them into a byte-wide UART through its enable/ready handshake.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int         NUM_REQ    = 4,
    parameter int         DATA_WIDTH = 16,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
    parameter int         ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset_b,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [7:0]                    uart_tx_data,
    output logic                          uart_tx_en,
    input  logic                          uart_tx_ready,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           grant_id
);

    localparam int BPW     = bytes_per_word(DATA_WIDTH);
    localparam int PKT_LEN = BPW + 3;
    localparam int IDX_W   = $clog2(PKT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              chk_q, chk_d;
    logic [7:0]              txd_q, txd_d;

    logic [ID_WIDTH-1:0]     arb_id;
    logic                    arb_valid;
    logic [DATA_WIDTH-1:0]   sel_word;
    logic [7:0]              cur_byte;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .ptr_i       (ptr_q),
        .req_i       (req_valid),
        .gnt_id_o    (arb_id),
        .gnt_valid_o (arb_valid)
    );

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_id == ID_WIDTH'(i)) begin
                sel_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Index 0 is SYNC, 1 is HEADER, then data MSB-first, last is the checksum.
    always_comb begin
        cur_byte = SYNC_BYTE;
        if (idx_q == IDX_W'(1)) begin
            cur_byte = 8'(id_q);
        end else if (idx_q == LAST_IDX) begin
            cur_byte = chk_q;
        end else begin
            for (int b = 0; b < BPW; b++) begin
                if (idx_q == IDX_W'(b + 2)) begin
                    cur_byte = word_q[DATA_WIDTH-8-8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        word_d     = word_q;
        idx_d      = idx_q;
        chk_d      = chk_q;
        txd_d      = txd_q;
        req_ack    = '0;
        uart_tx_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (arb_valid) begin
                    word_d  = sel_word;
                    id_d    = arb_id;
                    req_ack = NUM_REQ'(1) << arb_id;
                    ptr_d   = (arb_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : arb_id + 1'b1;
                    idx_d   = '0;
                    chk_d   = '0;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (uart_tx_ready) begin
                    uart_tx_en = 1'b1;
                    txd_d      = cur_byte;
                    // SYNC and the checksum byte itself stay out of the checksum.
                    if (idx_q != '0 && idx_q != LAST_IDX) chk_d = chk_q ^ cur_byte;
                    state_d    = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            txd_q   <= txd_d;
        end
    end

    assign uart_tx_data = uart_tx_en ? cur_byte : txd_q;
    assign busy         = (state_q != ST_IDLE);
    assign grant_id     = id_q;

endmodule
